// File: rtl/write_line_len_sum.sv
// write_line_len_sum
//
// Write-side burst-length scheduler for the VDMA write path. At each fsync it
// computes how many AXI words make up one segment (the whole frame in ONCE
// mode, one line in LINE mode). It then issues each segment as a run of
// NOR_BURST_LEN bursts followed by one short tail burst. A burst is requested
// only once the input FIFO holds enough words for it. A one-cycle frame_done
// pulse follows the completion of the last burst of the frame.
//
// Parameters:
//   NOR_BURST_LEN  normal burst length in AXI words (< 2**LSIZE)
//   MODE           "ONCE" = whole frame is one segment, "LINE" = one per line
//   AXI_DSIZE      AXI data width in bits (power of two, >= 2)
//   DSIZE          pixel width in bits
//   LSIZE          width of burst_len
//
// Ports:
//   clock        sole clock
//   rst_n        asynchronous active-low reset
//   vactive      active lines per frame, sampled at fsync
//   hactive      active pixels per line, sampled at fsync
//   fsync        one-cycle frame start pulse; aborts any frame in progress
//   fifo_count   AXI words available in the input FIFO
//   burst_ack    master accepted the current request
//   burst_done   one-cycle pulse on the last written beat of the burst
//   burst_req    burst request level
//   burst_len    words in the requested burst, stable while burst_req=1
//   tail_status  current burst (REQ/DONE) is shorter than NOR_BURST_LEN
//   frame_done   one-cycle pulse once every burst of the frame completed
//   overrun      sticky flag: fsync arrived mid-frame
//
// Optional feature: define WRITE_LEN_SUM_OVERRUN_EN to enable the sticky
// overrun flag. When the macro is not defined, overrun is tied to 0.

module write_line_len_sum #(
  parameter int    NOR_BURST_LEN = 200,
  parameter string MODE          = "ONCE",
  parameter int    AXI_DSIZE     = 256,
  parameter int    DSIZE         = 24,
  parameter int    LSIZE         = 9
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic             fsync,
  input  logic [LSIZE:0]   fifo_count,
  input  logic             burst_ack,
  input  logic             burst_done,
  output logic             burst_req,
  output logic [LSIZE-1:0] burst_len,
  output logic             tail_status,
  output logic             frame_done,
  output logic             overrun
);

  localparam int             SHIFT   = $clog2(AXI_DSIZE);
  // 40 significant bits remain after the divide-by-shift.
  localparam int             PW      = 40 + SHIFT;
  localparam bit             IS_LINE = (MODE == "LINE");
  localparam logic [LSIZE-1:0] NOR_LEN = LSIZE'(NOR_BURST_LEN);
  localparam logic [31:0]    NOR32   = 32'(NOR_BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC1,
    S_CALC2,
    S_WAIT,
    S_REQ,
    S_DONE,
    S_END
  } state_t;

  state_t           state_reg;
  logic [15:0]      vactive_reg;
  logic [15:0]      hactive_reg;
  logic [PW-1:0]    prod_reg;
  logic [31:0]      seg_words_reg;
  logic [31:0]      remaining_reg;
  logic [15:0]      lines_left_reg;
  logic [LSIZE-1:0] cur_len_reg;
  logic             burst_req_reg;
  logic [LSIZE-1:0] burst_len_reg;
  logic             tail_status_reg;
  logic             frame_done_reg;

  logic [31:0] bits_w;
  logic [39:0] quot_w;
  logic [31:0] seg_w;
  logic [15:0] lines_init_w;
  logic [31:0] rem_sub_w;

  // Length of the next burst: a full burst, or whatever is left of the segment.
  function automatic logic [LSIZE-1:0] min_len(input logic [31:0] r);
    return (r < NOR32) ? r[LSIZE-1:0] : NOR_LEN;
  endfunction

  always_comb begin
    bits_w       = IS_LINE ? {16'd0, hactive_reg}
                           : 32'(vactive_reg) * 32'(hactive_reg);
    // Round up: add one word when any bit is shifted out.
    quot_w       = prod_reg[PW-1:SHIFT] + {39'd0, |prod_reg[SHIFT-1:0]};
    // seg_words is held in 32 bits; saturate rather than wrap.
    seg_w        = (|quot_w[39:32]) ? 32'hFFFF_FFFF : quot_w[31:0];
    lines_init_w = IS_LINE ? vactive_reg : 16'd1;
    rem_sub_w    = remaining_reg - 32'(cur_len_reg);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      vactive_reg     <= '0;
      hactive_reg     <= '0;
      prod_reg        <= '0;
      seg_words_reg   <= '0;
      remaining_reg   <= '0;
      lines_left_reg  <= '0;
      cur_len_reg     <= '0;
      burst_req_reg   <= 1'b0;
      burst_len_reg   <= '0;
      tail_status_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (fsync) begin
        // A new frame always restarts the calculation, whatever the state;
        // it takes priority over a same-cycle ack or done.
        vactive_reg     <= vactive;
        hactive_reg     <= hactive;
        burst_req_reg   <= 1'b0;
        tail_status_reg <= 1'b0;
        state_reg       <= S_CALC1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            state_reg <= S_IDLE;
          end
          S_CALC1: begin
            prod_reg  <= PW'(bits_w) * PW'(DSIZE);
            state_reg <= S_CALC2;
          end
          S_CALC2: begin
            seg_words_reg  <= seg_w;
            remaining_reg  <= seg_w;
            lines_left_reg <= lines_init_w;
            cur_len_reg    <= min_len(seg_w);
            if (seg_w == 32'd0 || lines_init_w == 16'd0) begin
              frame_done_reg <= 1'b1;
              state_reg      <= S_END;
            end else begin
              state_reg <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (fifo_count >= {1'b0, cur_len_reg}) begin
              burst_req_reg   <= 1'b1;
              burst_len_reg   <= cur_len_reg;
              tail_status_reg <= (cur_len_reg < NOR_LEN);
              state_reg       <= S_REQ;
            end
          end
          S_REQ: begin
            if (burst_ack) begin
              burst_req_reg <= 1'b0;
              state_reg     <= S_DONE;
            end
          end
          S_DONE: begin
            if (burst_done) begin
              tail_status_reg <= 1'b0;
              if (rem_sub_w == 32'd0) begin
                if (lines_left_reg > 16'd1) begin
                  // Next line: reload the full segment.
                  lines_left_reg <= lines_left_reg - 16'd1;
                  remaining_reg  <= seg_words_reg;
                  cur_len_reg    <= min_len(seg_words_reg);
                  state_reg      <= S_WAIT;
                end else begin
                  remaining_reg  <= 32'd0;
                  frame_done_reg <= 1'b1;
                  state_reg      <= S_END;
                end
              end else begin
                remaining_reg <= rem_sub_w;
                cur_len_reg   <= min_len(rem_sub_w);
                state_reg     <= S_WAIT;
              end
            end
          end
          S_END: begin
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef WRITE_LEN_SUM_OVERRUN_EN
  logic overrun_reg;

  // END counts as idle: the frame has completed, so a new fsync is on time.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (fsync && state_reg != S_IDLE && state_reg != S_END) begin
      overrun_reg <= 1'b1;
    end
  end

  assign overrun = overrun_reg;
`else
  assign overrun = 1'b0;
`endif

  assign burst_req   = burst_req_reg;
  assign burst_len   = burst_len_reg;
  assign tail_status = tail_status_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_write_line_len_sum.sv
module tb_write_line_len_sum;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] vactive = '0;
  logic [15:0] hactive = '0;
  logic        fsync = 1'b0;
  logic [9:0]  fifo_count = '0;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic        sel_line = 1'b0;

  logic       req_o, req_l, tail_o, tail_l, fd_o, fd_l, ovr_o, ovr_l;
  logic [8:0] len_o, len_l;

  logic       req, tail, fd, ovr;
  logic [8:0] len;

  int vectors = 0;
  int miscompares = 0;
  bit exp_ovr;

  always #5 clock = ~clock;

  write_line_len_sum #(.MODE("ONCE")) dut_once (
    .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive),
    .fsync(fsync && !sel_line), .fifo_count(fifo_count),
    .burst_ack(ack && !sel_line), .burst_done(done && !sel_line),
    .burst_req(req_o), .burst_len(len_o), .tail_status(tail_o),
    .frame_done(fd_o), .overrun(ovr_o)
  );

  write_line_len_sum #(.MODE("LINE")) dut_line (
    .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive),
    .fsync(fsync && sel_line), .fifo_count(fifo_count),
    .burst_ack(ack && sel_line), .burst_done(done && sel_line),
    .burst_req(req_l), .burst_len(len_l), .tail_status(tail_l),
    .frame_done(fd_l), .overrun(ovr_l)
  );

  assign req  = sel_line ? req_l  : req_o;
  assign len  = sel_line ? len_l  : len_o;
  assign tail = sel_line ? tail_l : tail_o;
  assign fd   = sel_line ? fd_l   : fd_o;
  assign ovr  = sel_line ? ovr_l  : ovr_o;

  task automatic do_reset();
    rst_n = 1'b0; fsync = 0; ack = 0; done = 0; fifo_count = '0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    @(negedge clock);
    fsync = 1'b0;
  endtask

  task automatic wait_req(input int max, output bit ok);
    for (int i = 0; i < max && req !== 1'b1; i++) @(negedge clock);
    ok = (req === 1'b1);
  endtask

  // One complete burst: wait for request, check it, ack, then done.
  // Returns on the cycle after burst_done was sampled.
  task automatic do_burst(input string tag, input int exp_len, input bit exp_tail,
                          input bit exp_fd, input logic [9:0] fifo_after);
    bit ok;
    wait_req(20, ok);
    vectors++; if (!ok) begin $display("FAIL %s req_timeout got req=%0b want 1", tag, req); miscompares++; end
    vectors++; if (len !== 9'(exp_len)) begin $display("FAIL %s burst_len got %0d want %0d", tag, len, exp_len); miscompares++; end
    vectors++; if (tail !== exp_tail) begin $display("FAIL %s tail_req got %0b want %0b", tag, tail, exp_tail); miscompares++; end
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    vectors++; if (req !== 1'b0) begin $display("FAIL %s req_drop got %0b want 0", tag, req); miscompares++; end
    vectors++; if (tail !== exp_tail) begin $display("FAIL %s tail_done got %0b want %0b", tag, tail, exp_tail); miscompares++; end
    @(negedge clock);
    done = 1'b1;
    fifo_count = fifo_after;
    @(negedge clock);
    done = 1'b0;
    vectors++; if (fd !== exp_fd) begin $display("FAIL %s frame_done got %0b want %0b", tag, fd, exp_fd); miscompares++; end
    $display("%s: burst len=%0d tail=%0b frame_done=%0b", tag, len, tail, fd);
  endtask

  task automatic test_reset();
    sel_line = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if ({req_o, len_o, tail_o, fd_o, ovr_o} !== 13'd0) begin $display("FAIL reset_once got %0h want 0", {req_o, len_o, tail_o, fd_o, ovr_o}); miscompares++; end
    vectors++; if ({req_l, len_l, tail_l, fd_l, ovr_l} !== 13'd0) begin $display("FAIL reset_line got %0h want 0", {req_l, len_l, tail_l, fd_l, ovr_l}); miscompares++; end
    $display("reset: outputs once=%0h line=%0h", {req_o, len_o, tail_o, fd_o, ovr_o}, {req_l, len_l, tail_l, fd_l, ovr_l});
    do_reset();
  endtask

  task automatic test_once_small();
    sel_line = 1'b0;
    do_reset();
    vactive = 16'd4; hactive = 16'd100; fifo_count = 10'd511;
    pulse_fsync();
    vectors++; if (req !== 1'b0) begin $display("FAIL once_lat_n1 got %0b want 0", req); miscompares++; end
    repeat (2) @(negedge clock);
    vectors++; if (req !== 1'b0) begin $display("FAIL once_lat_n3 got %0b want 0", req); miscompares++; end
    @(negedge clock);
    vectors++; if (req !== 1'b1) begin $display("FAIL once_lat_n4 got %0b want 1", req); miscompares++; end
    do_burst("once_100x4", 38, 1'b1, 1'b1, 10'd511);
    @(negedge clock);
    vectors++; if (fd !== 1'b0) begin $display("FAIL once_fd_width got %0b want 0", fd); miscompares++; end
    vectors++; if (ovr !== 1'b0) begin $display("FAIL once_ovr got %0b want 0", ovr); miscompares++; end
  endtask

  task automatic test_line_1920();
    sel_line = 1'b1;
    do_reset();
    vactive = 16'd3; hactive = 16'd1920; fifo_count = 10'd511;
    pulse_fsync();
    do_burst("line1920_l0", 180, 1'b1, 1'b0, 10'd511);
    // back-to-back: next request exactly two cycles after burst_done
    vectors++; if (req !== 1'b0) begin $display("FAIL b2b_wait got %0b want 0", req); miscompares++; end
    @(negedge clock);
    vectors++; if (req !== 1'b1) begin $display("FAIL b2b_req got %0b want 1", req); miscompares++; end
    do_burst("line1920_l1", 180, 1'b1, 1'b0, 10'd511);
    do_burst("line1920_l2", 180, 1'b1, 1'b1, 10'd511);
  endtask

  task automatic test_line_3000();
    sel_line = 1'b1;
    do_reset();
    vactive = 16'd2; hactive = 16'd3000; fifo_count = 10'd511;
    pulse_fsync();
    do_burst("line3000_a", 200, 1'b0, 1'b0, 10'd511);
    do_burst("line3000_b", 82,  1'b1, 1'b0, 10'd511);
    do_burst("line3000_c", 200, 1'b0, 1'b0, 10'd511);
    do_burst("line3000_d", 82,  1'b1, 1'b1, 10'd511);
  endtask

  task automatic test_fifo_gate();
    bit ok;
    sel_line = 1'b1;
    do_reset();
    vactive = 16'd1; hactive = 16'd3000; fifo_count = 10'd511;
    pulse_fsync();
    do_burst("gate_first", 200, 1'b0, 1'b0, 10'd81);
    for (int i = 0; i < 6; i++) begin
      vectors++; if (req !== 1'b0) begin $display("FAIL gate_hold%0d got %0b want 0", i, req); miscompares++; end
      @(negedge clock);
    end
    $display("gate: fifo_count=81 held, req=%0b", req);
    fifo_count = 10'd82;
    @(negedge clock);
    wait_req(1, ok);
    vectors++; if (!ok) begin $display("FAIL gate_release got %0b want 1", req); miscompares++; end
    do_burst("gate_tail", 82, 1'b1, 1'b1, 10'd511);
  endtask

  task automatic test_abort();
    bit ok;
    sel_line = 1'b0;
    do_reset();
    vactive = 16'd1; hactive = 16'd3000; fifo_count = 10'd511;
    pulse_fsync();
    do_burst("abort_b1", 200, 1'b0, 1'b0, 10'd511);
    wait_req(20, ok);
    vectors++; if (!ok || len !== 9'd82) begin $display("FAIL abort_b2_req got req=%0b len=%0d want 1/82", req, len); miscompares++; end
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    // now in DONE of burst 2: fsync and burst_done together, fsync wins
    fsync = 1'b1; done = 1'b1;
    @(negedge clock);
    fsync = 1'b0; done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (fd !== 1'b0 || req !== 1'b0) begin $display("FAIL abort_quiet%0d got fd=%0b req=%0b want 0/0", i, fd, req); miscompares++; end
      @(negedge clock);
    end
    vectors++; if (ovr !== exp_ovr) begin $display("FAIL abort_overrun got %0b want %0b", ovr, exp_ovr); miscompares++; end
    $display("abort: overrun=%0b", ovr);
    do_burst("abort_r1", 200, 1'b0, 1'b0, 10'd511);
    do_burst("abort_r2", 82,  1'b1, 1'b1, 10'd511);
    vectors++; if (ovr !== exp_ovr) begin $display("FAIL abort_overrun_sticky got %0b want %0b", ovr, exp_ovr); miscompares++; end
  endtask

  task automatic test_zero();
    sel_line = 1'b0;
    do_reset();
    vactive = 16'd4; hactive = 16'd0; fifo_count = 10'd511;
    pulse_fsync();
    vectors++; if (fd !== 1'b0) begin $display("FAIL zero_fd_n1 got %0b want 0", fd); miscompares++; end
    @(negedge clock);
    vectors++; if (fd !== 1'b0) begin $display("FAIL zero_fd_n2 got %0b want 0", fd); miscompares++; end
    @(negedge clock);
    vectors++; if (fd !== 1'b1) begin $display("FAIL zero_fd_n3 got %0b want 1", fd); miscompares++; end
    @(negedge clock);
    vectors++; if (fd !== 1'b0) begin $display("FAIL zero_fd_n4 got %0b want 0", fd); miscompares++; end
    repeat (3) @(negedge clock);
    vectors++; if (req !== 1'b0) begin $display("FAIL zero_req got %0b want 0", req); miscompares++; end
    $display("zero: hactive=0 frame_done seen, req=%0b", req);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    sel_line = 1'b0;
    do_reset();
    vactive = 16'd4; hactive = 16'd100; fifo_count = 10'd511;
    pulse_fsync();
    wait_req(20, ok);
    vectors++; if (!ok) begin $display("FAIL rst_mid_req got %0b want 1", req); miscompares++; end
    rst_n = 1'b0;
    #1;
    vectors++; if (req !== 1'b0 || len !== 9'd0) begin $display("FAIL rst_mid_clear got req=%0b len=%0d want 0/0", req, len); miscompares++; end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (6) @(negedge clock);
    vectors++; if (req !== 1'b0) begin $display("FAIL rst_mid_no_pending got %0b want 0", req); miscompares++; end
    $display("reset mid burst: req=%0b", req);
  endtask

  initial begin
`ifdef WRITE_LEN_SUM_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    test_reset();
    test_once_small();
    test_line_1920();
    test_line_3000();
    test_fifo_gate();
    test_abort();
    test_zero();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
